// File: rtl/trivium_byte_if.sv
// Byte-wide valid/ready front end for the serial Trivium core: serialises key/IV and data
// bytes LSB first and reassembles cipher bits into bytes. Define TRIV_IF_ERR_EN for err_o.
module trivium_byte_if #(
  parameter int KIV_BYTES = 20,
  parameter int CORE_LAT  = 0
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_kiv_i,
  input  logic       in_end_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       core_dat_o,
  output logic       core_get_dat_o,
  output logic       core_ld_keys_o,
  output logic       core_end_o,
  input  logic       core_dat_i,
  input  logic       core_ready_i
`ifdef TRIV_IF_ERR_EN
  ,
  output logic       err_o
`endif
);

  localparam int BCW = (KIV_BYTES > 1) ? $clog2(KIV_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(KIV_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, KIV_PRE, KIV_SHIFT, WARM, RDY, DAT_PRE, DAT_SHIFT, DAT_GAP, END
  } state_t;

  state_t         state_reg, state_next;
  logic           live_reg;
  logic [7:0]     shreg_reg;
  logic [7:0]     cap_reg;
  logic [7:0]     out_data_reg;
  logic           out_valid_reg;
  logic [2:0]     bit_cnt_reg;
  logic [BCW-1:0] byte_cnt_reg;
  logic           gap_cnt_reg;
  logic           is_kiv, is_dat;
  logic           rdy_open;
  logic           gap_done;
  logic           load_byte, shift_en, cap_en;

  // End command wins over byte contents.
  assign is_kiv   = in_kiv_i & ~in_end_i;
  assign is_dat   = ~in_kiv_i & ~in_end_i;
  assign rdy_open = ~out_valid_reg | out_ready_i;
  assign gap_done = (gap_cnt_reg == 1'(CORE_LAT));

  always_comb begin
    state_next     = state_reg;
    in_ready_o     = 1'b0;
    core_get_dat_o = 1'b0;
    core_ld_keys_o = 1'b0;
    core_end_o     = 1'b0;
    load_byte      = 1'b0;
    shift_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_o = live_reg;
        if (live_reg && in_valid_i && is_kiv) begin
          load_byte  = 1'b1;
          state_next = KIV_PRE;
        end
      end
      KIV_PRE: begin
        core_get_dat_o = 1'b1;
        state_next     = KIV_SHIFT;
      end
      KIV_SHIFT: begin
        core_get_dat_o = 1'b1;
        if (bit_cnt_reg != 3'd7) begin
          shift_en = 1'b1;
        end else if (byte_cnt_reg == LAST_BYTE) begin
          core_ld_keys_o = 1'b1;
          state_next     = WARM;
        end else begin
          // Bit 7 stays on core_dat_o until the next key/IV byte shows up.
          in_ready_o = 1'b1;
          load_byte  = in_valid_i & is_kiv;
        end
      end
      WARM: begin
        if (core_ready_i) state_next = RDY;
      end
      RDY: begin
        in_ready_o = rdy_open;
        if (rdy_open && in_valid_i) begin
          if (in_end_i) begin
            state_next = END;
          end else if (is_dat) begin
            load_byte  = 1'b1;
            state_next = DAT_PRE;
          end
        end
      end
      DAT_PRE: begin
        core_get_dat_o = 1'b1;
        state_next     = DAT_SHIFT;
      end
      DAT_SHIFT: begin
        core_get_dat_o = 1'b1;
        shift_en       = 1'b1;
        if (bit_cnt_reg == 3'd7) state_next = DAT_GAP;
      end
      DAT_GAP: begin
        if (gap_done) state_next = RDY;
      end
      END: begin
        core_end_o = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign core_dat_o  = core_get_dat_o & shreg_reg[0];
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_reg     <= IDLE;
      live_reg      <= 1'b0;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      gap_cnt_reg   <= 1'b0;
      cap_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (load_byte) begin
        shreg_reg   <= in_data_i;
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        shreg_reg   <= {1'b0, shreg_reg[7:1]};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      if (load_byte && state_reg == IDLE) begin
        byte_cnt_reg <= '0;
      end else if (load_byte && state_reg == KIV_SHIFT) begin
        byte_cnt_reg <= byte_cnt_reg + BCW'(1);
      end
      gap_cnt_reg <= (state_reg == DAT_GAP) && !gap_done;
      if (cap_en) cap_reg <= {core_dat_i, cap_reg[7:1]};
      // The buffer is always empty by the time a byte completes, so loading never overwrites.
      if (state_reg == DAT_GAP && gap_done) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= cap_reg;
      end else if (out_valid_reg && out_ready_i) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Cipher bit k arrives CORE_LAT cycles after data bit k is presented.
  generate
    if (CORE_LAT == 0) begin : g_cap_lat0
      assign cap_en = (state_reg == DAT_SHIFT);
    end else begin : g_cap_lat1
      logic cap_en_reg;
      always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) cap_en_reg <= 1'b0;
        else          cap_en_reg <= (state_reg == DAT_SHIFT);
      end
      assign cap_en = cap_en_reg;
    end
  endgenerate

`ifdef TRIV_IF_ERR_EN
  logic err_reg;
  logic drop;
  logic core_lost;

  assign drop = in_valid_i & in_ready_o &
                (((state_reg == IDLE) & ~is_kiv) | ((state_reg == RDY) & in_kiv_i & ~in_end_i));
  assign core_lost = ~core_ready_i &
                     ((state_reg == RDY) | (state_reg == DAT_PRE) |
                      (state_reg == DAT_SHIFT) | (state_reg == DAT_GAP));

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)               err_reg <= 1'b0;
    else if (drop || core_lost) err_reg <= 1'b1;
  end
  assign err_o = err_reg;
`endif

endmodule

// File: tb/tb_trivium_byte_if.sv
// Scoreboard bench for trivium_byte_if: lane 0 uses CORE_LAT=0, lane 1 CORE_LAT=1, each with
// a small core model that XORs data bits with keystream byte 0x3C.
`timescale 1ns/1ps
module tb_trivium_byte_if;
  localparam int NL    = 2;
  localparam int STALL = 5;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic [7:0] ks = 8'h3C;

  logic [NL-1:0] in_valid, in_ready, in_kiv, in_end, out_valid, out_ready;
  logic [NL-1:0] core_dat, get_dat, ld_keys, core_end, core_dat_i, core_ready;
  logic [7:0]    in_data  [NL];
  logic [7:0]    out_data [NL];
`ifdef TRIV_IF_ERR_EN
  logic [NL-1:0] err;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    logic       prev_get;
    logic [2:0] k;
    logic       raw;

    trivium_byte_if #(.KIV_BYTES(20), .CORE_LAT(gi)) u_dut (
      .clk_i         (clk),
      .n_rst_i       (n_rst),
      .in_valid_i    (in_valid[gi]),
      .in_ready_o    (in_ready[gi]),
      .in_data_i     (in_data[gi]),
      .in_kiv_i      (in_kiv[gi]),
      .in_end_i      (in_end[gi]),
      .out_valid_o   (out_valid[gi]),
      .out_ready_i   (out_ready[gi]),
      .out_data_o    (out_data[gi]),
      .core_dat_o    (core_dat[gi]),
      .core_get_dat_o(get_dat[gi]),
      .core_ld_keys_o(ld_keys[gi]),
      .core_end_o    (core_end[gi]),
      .core_dat_i    (core_dat_i[gi]),
      .core_ready_i  (core_ready[gi])
`ifdef TRIV_IF_ERR_EN
      ,
      .err_o         (err[gi])
`endif
    );

    // First get_dat cycle of a burst carries no bit; keystream index restarts there.
    always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        prev_get <= 1'b0;
        k        <= 3'd0;
      end else begin
        prev_get <= get_dat[gi];
        if (get_dat[gi] && !prev_get) k <= 3'd0;
        else if (get_dat[gi])         k <= k + 3'd1;
      end
    end
    assign raw = core_dat[gi] ^ ks[k];

    if (gi == 0) begin : g_core_lat0
      assign core_dat_i[gi] = raw;
    end else begin : g_core_lat1
      logic raw_q;
      always @(posedge clk) raw_q <= raw;
      assign core_dat_i[gi] = raw_q;
    end
  end

  typedef struct {
    logic [7:0] data;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cur      = 0;
  logic kiv_seq[$];
  int   ld_seen, ld_cnt, end_cyc, get_cnt, t_valid;
  logic ov_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor for the active lane: serial capture, strobe counts, scoreboard pops.
  always @(negedge clk) begin
    if (!n_rst) begin
      ov_prev = 1'b0;
    end else begin
      get_cnt += int'(get_dat[cur]);
      ld_cnt  += int'(ld_keys[cur]);
      end_cyc += int'(core_end[cur]);
      if (get_dat[cur] && ld_seen == 0) begin
        kiv_seq.push_back(core_dat[cur]);
        if (ld_keys[cur]) ld_seen = 1;
      end
      if (out_valid[cur] && !ov_prev) t_valid = cyc;
      ov_prev = out_valid[cur];
      if (out_valid[cur] && out_ready[cur]) begin
        chk("out_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("lane %0d out 0x%02h exp 0x%02h latency %0d", cur, out_data[cur], e.data,
                   t_valid - e.t);
          chk("out_data", 32'(out_data[cur]), 32'(e.data));
          chk("out_latency", t_valid - e.t, 10 + cur);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic kv, input logic e, input logic expect_out);
    int t = 0;
    in_valid[cur] = 1'b1;
    in_data[cur]  = d;
    in_kiv[cur]   = kv;
    in_end[cur]   = e;
    @(negedge clk);
    while (!in_ready[cur] && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    in_valid[cur] = 1'b0;
    in_kiv[cur]   = 1'b0;
    in_end[cur]   = 1'b0;
    chk("send_accept", 32'(t < 300), 1);
    if (t < 300 && expect_out) sb.push_back('{d ^ ks, cyc});
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && sb.size() != 0; t++) idle(1);
    chk("drain", sb.size(), 0);
  endtask

  task automatic check_outs_zero(input string tag);
    chk(tag, {24'd0, in_ready[cur], out_valid[cur], get_dat[cur], ld_keys[cur],
              core_end[cur], core_dat[cur], 2'b00} | 32'(out_data[cur]), 0);
  endtask

  // Loads key 0x00..09 and IV 0x0A..13; stalls STALL cycles before byte stall_at.
  task automatic load_keys(input int stall_at);
    logic       exp_seq[$];
    logic [7:0] b;
    int         mism = 0;
    kiv_seq.delete();
    ld_seen = 0;
    ld_cnt  = 0;
    for (int n = 0; n < 20; n++) begin
      if (n == stall_at) idle(7 + STALL);
      send(8'(n), 1'b1, 1'b0, 1'b0);
    end
    for (int t = 0; t < 40 && ld_seen == 0; t++) idle(1);
    chk("ld_keys_seen", ld_seen, 1);
    chk("ld_keys_pulses", ld_cnt, 1);
    for (int n = 0; n < 20; n++) begin
      b = 8'(n);
      for (int i = 0; i < 8; i++) exp_seq.push_back(b[i]);
      if (n == stall_at - 1) repeat (STALL) exp_seq.push_back(b[7]);
    end
    chk("kiv_get_cycles", kiv_seq.size(), 1 + exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i + 1 < kiv_seq.size(); i++)
      if (kiv_seq[i + 1] !== exp_seq[i]) mism++;
    chk("kiv_bit_errors", mism, 0);
    idle(1);
    chk("warm_in_ready", 32'(in_ready[cur]), 0);
    chk("warm_get_dat", 32'(get_dat[cur]), 0);
    idle(3);
    core_ready[cur] = 1'b1;
    idle(1);
    chk("rdy_in_ready", 32'(in_ready[cur]), 1);
  endtask

  task automatic run_lane(input int l);
    cur        = l;
    in_valid   = '0;
    in_kiv     = '0;
    in_end     = '0;
    out_ready  = '0;
    core_ready = '0;
    for (int i = 0; i < NL; i++) in_data[i] = 8'h00;
    sb.delete();
    n_rst = 1'b0;
    #1;
    check_outs_zero("reset_outputs");
    idle(2);
    n_rst = 1'b1;
    #1;
    chk("in_ready_before_clk", 32'(in_ready[cur]), 0);
    idle(1);
    chk("in_ready_idle", 32'(in_ready[cur]), 1);
    out_ready[cur] = 1'b1;

    load_keys(-1);

    send(8'hA5, 1'b0, 1'b0, 1'b1);
    drain();
    send(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: second byte must wait for the first to be taken.
    out_ready[cur] = 1'b0;
    send(8'h12, 1'b0, 1'b0, 1'b1);
    fork
      send(8'h34, 1'b0, 1'b0, 1'b1);
      begin
        idle(20);
        chk("bp_in_ready", 32'(in_ready[cur]), 0);
        chk("bp_out_valid", 32'(out_valid[cur]), 1);
        chk("bp_out_hold", 32'(out_data[cur]), 32'(8'h12 ^ ks));
        out_ready[cur] = 1'b1;
      end
    join
    drain();

    end_cyc = 0;
`ifdef TRIV_IF_ERR_EN
    chk("err_clear", 32'(err[cur]), 0);
`endif
    send(8'h00, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("end_cycles", end_cyc, 1);
    chk("idle_after_end", 32'(in_ready[cur]), 1);
    get_cnt = 0;
    send(8'h77, 1'b0, 1'b0, 1'b0);
    idle(12);
    chk("drop_no_out", 32'(out_valid[cur]), 0);
    chk("drop_no_get", get_cnt, 0);
`ifdef TRIV_IF_ERR_EN
    chk("err_on_drop", 32'(err[cur]), 1);
`endif

    // Abort in the middle of key/IV byte 4, then reload with a stall.
    for (int n = 0; n < 5; n++) send(8'(n), 1'b1, 1'b0, 1'b0);
    idle(3);
    n_rst = 1'b0;
    core_ready[cur] = 1'b0;
    #1;
    check_outs_zero("abort_outputs");
    sb.delete();
    idle(2);
    n_rst = 1'b1;
    idle(1);
    chk("abort_idle", 32'(in_ready[cur]), 1);
`ifdef TRIV_IF_ERR_EN
    chk("err_reset", 32'(err[cur]), 0);
`endif
    load_keys(7);
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    for (int l = 0; l < NL; l++) run_lane(l);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
